// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Program-counter and instruction-fetch stage. Keeps exactly one instruction
// memory request in flight, buffers the returned word and offers it to decode
// over a valid/ready handshake. A resolved control transfer (redirect) from
// the branch comparator downstream overrides every other event and steers the
// next fetch to the (word-aligned) target. A response that belongs to a
// request issued before a redirect is discarded using the kill flag.
//
// Parameters
//   XLEN      address / instruction width
//   RESET_PC  first fetch address after reset
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   imem_req_valid    fetch request valid (registered)
//   imem_req_ready    memory accepts the request this cycle
//   imem_addr         fetch address, low two bits always zero (registered)
//   imem_rsp_valid    one-cycle response pulse
//   imem_rsp_data     fetched instruction word
//   inst_valid        instruction available to decode
//   inst_ready        decode accepts the instruction
//   inst, inst_pc     instruction word and its address
//   redirect          taken branch / jump resolved this cycle
//   redirect_pc       redirect target, low two bits ignored
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
  localparam logic [XLEN-1:0] RESET_PC_A = RESET_PC & ALIGN_MASK;

  state_t          state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic [XLEN-1:0] req_pc, req_pc_n;
  logic            kill, kill_n;
  logic [XLEN-1:0] inst_n, inst_pc_n;
  logic            inst_valid_n;

  logic            req_fire;
  logic [XLEN-1:0] target;

  // The request handshake only counts while the registered valid is high;
  // right after reset release the state is REQ but valid is still low.
  assign req_fire = imem_req_valid & imem_req_ready;
  assign target   = redirect_pc & ALIGN_MASK;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n      = state;
    pc_n         = pc;
    req_pc_n     = req_pc;
    kill_n       = kill;
    inst_n       = inst;
    inst_pc_n    = inst_pc;
    inst_valid_n = inst_valid;

    unique case (state)
      S_REQ: begin
        if (req_fire) begin
          // The old-address request has already been accepted by memory, so
          // its response must still be consumed and thrown away.
          req_pc_n = pc;
          state_n  = S_WAIT;
          if (redirect) begin
            kill_n = 1'b1;
            pc_n   = target;
          end
        end else if (redirect) begin
          pc_n = target;
        end
      end

      S_WAIT: begin
        if (redirect) begin
          pc_n = target;
          if (imem_rsp_valid) begin
            // Response arrives together with the redirect: drop it here,
            // nothing remains outstanding.
            kill_n  = 1'b0;
            state_n = S_REQ;
          end else begin
            kill_n = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (kill) begin
            kill_n  = 1'b0;
            state_n = S_REQ;
          end else begin
            inst_n       = imem_rsp_data;
            inst_pc_n    = req_pc;
            inst_valid_n = 1'b1;
            state_n      = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        // Redirect wins even over a same-cycle accept: the presented
        // instruction is wrong-path and fetch must not step to inst_pc+4.
        if (redirect) begin
          inst_valid_n = 1'b0;
          pc_n         = target;
          state_n      = S_REQ;
        end else if (inst_ready) begin
          inst_valid_n = 1'b0;
          pc_n         = inst_pc + XLEN'(4);
          state_n      = S_REQ;
        end
      end

      default: begin
        state_n      = S_REQ;
        kill_n       = 1'b0;
        inst_valid_n = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_REQ;
      pc             <= RESET_PC_A;
      req_pc         <= RESET_PC_A;
      kill           <= 1'b0;
      inst           <= '0;
      inst_pc        <= '0;
      inst_valid     <= 1'b0;
      imem_req_valid <= 1'b0;
      imem_addr      <= RESET_PC_A;
    end else begin
      state          <= state_n;
      pc             <= pc_n;
      req_pc         <= req_pc_n;
      kill           <= kill_n;
      inst           <= inst_n;
      inst_pc        <= inst_pc_n;
      inst_valid     <= inst_valid_n;
      // Request outputs are registered from the next state so the address
      // presented always matches the pc the request will record.
      imem_req_valid <= (state_n == S_REQ);
      imem_addr      <= pc_n & ALIGN_MASK;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Self-checking bench for fetch_unit. A behavioural instruction memory answers
// every accepted request after a programmable delay. Scenario tasks push the
// instructions decode is expected to consume into a scoreboard queue; a
// monitor pops and compares on each decode handshake and also watches the
// one-outstanding-request protocol.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int unsigned XLEN   = 32;
  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect;
  logic [31:0] redirect_pc;

  fetch_unit #(
    .XLEN    (XLEN),
    .RESET_PC(RST_PC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr     (imem_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // memory model controls
  int          mem_delay = 1;
  bit          ovr_en    = 1'b0;
  logic [31:0] ovr_addr  = '0;
  logic [31:0] ovr_data  = '0;

  // monitor state
  bit outstanding = 1'b0;
  bit prev_iv     = 1'b0;
  bit lat_chk     = 1'b0;
  int acc_cyc     = 0;

  function automatic logic [31:0] word(input logic [31:0] a);
    if (ovr_en && a == ovr_addr) return ovr_data;
    return {~a[15:0], a[15:0]};
  endfunction

  function automatic exp_t mk(input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.pc   = a;
    e.data = d;
    return e;
  endfunction

  // Instruction memory: handshake sampled mid-cycle, response driven just
  // after the clock edge mem_delay edges later, held for one cycle.
  initial begin
    logic [31:0] a;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (rst_n && imem_req_valid && imem_req_ready) begin
        a = imem_addr;
        repeat (mem_delay) @(posedge clk);
        #1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = word(a);
        @(posedge clk);
        #1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        outstanding = 1'b0;
        prev_iv     = 1'b0;
      end else begin
        if (imem_req_valid) begin
          n_checks++;
          if (outstanding || inst_valid) begin
            n_fail++;
            $display("FAIL single_outstanding: req_valid=1 with outstanding=%0b inst_valid=%0b (required both 0)",
                     outstanding, inst_valid);
          end
        end
        if (imem_rsp_valid) begin
          n_checks++;
          if (!outstanding) begin
            n_fail++;
            $display("FAIL rsp_without_req: response seen with no request outstanding");
          end
          outstanding = 1'b0;
        end
        if (imem_req_valid && imem_req_ready) begin
          outstanding = 1'b1;
          acc_cyc     = cyc;
        end
        if (inst_valid && inst_ready && !redirect) begin
          n_checks++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: inst=%h inst_pc=%h consumed, none expected", inst, inst_pc);
          end else begin
            e = sb.pop_front();
            if (inst !== e.data) begin
              n_fail++;
              $display("FAIL sb_inst: got %h required %h (pc %h)", inst, e.data, e.pc);
            end
            n_checks++;
            if (inst_pc !== e.pc) begin
              n_fail++;
              $display("FAIL sb_inst_pc: got %h required %h", inst_pc, e.pc);
            end
          end
        end
        if (lat_chk && inst_valid && !prev_iv) begin
          n_checks++;
          if (cyc - acc_cyc != 2) begin
            n_fail++;
            $display("FAIL latency: inst_valid %0d cycles after accept, required 2", cyc - acc_cyc);
          end
        end
        prev_iv = inst_valid;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (no checking inside)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n          = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b0;
    inst_ready     = 1'b0;
    sb.delete();
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  // Reset, then steer the first fetch to t while memory is not ready.
  task automatic reset_to(input logic [31:0] t);
    apply_reset();
    redirect    = 1'b1;
    redirect_pc = t;
    tick();
    redirect    = 1'b0;
  endtask

  task automatic drain(input int budget, output bit ok);
    ok         = 1'b0;
    inst_ready = 1'b1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    inst_ready = 1'b0;
  endtask

  task automatic wait_req(input bit need_rdy, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (imem_req_valid && (!need_rdy || imem_req_ready)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_iv(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (inst_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n          = 1'b1;
    redirect       = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b0;
    inst_ready     = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b required 0", imem_req_valid); end
    n_checks++;
    if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_inst_valid: got %b required 0", inst_valid); end
    n_checks++;
    if (inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst: got %h required 0", inst); end
    n_checks++;
    if (inst_pc !== 32'h0) begin n_fail++; $display("FAIL reset_inst_pc: got %h required 0", inst_pc); end
    n_checks++;
    if (imem_addr !== RST_PC) begin n_fail++; $display("FAIL reset_addr: got %h required %h", imem_addr, RST_PC); end
    repeat (2) tick();
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL release_no_req_before_edge: got %b required 0", imem_req_valid); end
    @(negedge clk);
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_addr !== RST_PC) begin
      n_fail++;
      $display("FAIL first_req: valid=%b addr=%h required 1/%h", imem_req_valid, imem_addr, RST_PC);
    end
  endtask

  task automatic test_basic();
    bit ok;
    apply_reset();
    imem_req_ready = 1'b1;
    lat_chk        = 1'b1;
    sb.push_back(mk(32'h100, word(32'h100)));
    sb.push_back(mk(32'h104, word(32'h104)));
    sb.push_back(mk(32'h108, word(32'h108)));
    drain(40, ok);
    lat_chk = 1'b0;
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL basic_timeout: %0d entries left, required 0", sb.size()); end
  endtask

  task automatic test_backpressure();
    bit ok;
    apply_reset();
    ovr_en         = 1'b1;
    ovr_addr       = 32'h100;
    ovr_data       = 32'h0050_0093;
    imem_req_ready = 1'b1;
    wait_iv(10, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL bp_no_valid: inst_valid never rose"); end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (inst !== 32'h0050_0093 || inst_pc !== 32'h100 || inst_valid !== 1'b1 || imem_req_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold: inst=%h pc=%h iv=%b rv=%b required 00500093/00000100/1/0",
                 inst, inst_pc, inst_valid, imem_req_valid);
      end
      @(negedge clk);
    end
    sb.push_back(mk(32'h100, 32'h0050_0093));
    sb.push_back(mk(32'h104, word(32'h104)));
    tick();
    inst_ready = 1'b1;
    wait_req(1'b0, 10, ok);
    n_checks++;
    if (!ok || imem_addr !== 32'h104) begin
      n_fail++;
      $display("FAIL bp_next_addr: addr=%h seen=%0b required 00000104", imem_addr, ok);
    end
    drain(20, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL bp_drain: %0d entries left, required 0", sb.size()); end
    ovr_en = 1'b0;
  endtask

  task automatic test_redirect_wait();
    bit ok;
    bit seen;
    apply_reset();
    mem_delay      = 2;
    ovr_en         = 1'b1;
    ovr_addr       = 32'h100;
    ovr_data       = 32'hDEAD_BEEF;
    imem_req_ready = 1'b1;
    wait_req(1'b1, 10, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rw_no_handshake"); end
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    tick();
    redirect  = 1'b0;
    mem_delay = 1;
    sb.push_back(mk(32'h200, word(32'h200)));
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (imem_req_valid) begin
        seen = 1'b1;
        break;
      end
      n_checks++;
      if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rw_dropped: inst_valid=%b inst=%h required 0", inst_valid, inst); end
    end
    n_checks++;
    if (!seen || imem_addr !== 32'h200) begin
      n_fail++;
      $display("FAIL rw_next_addr: addr=%h seen=%0b required 00000200", imem_addr, seen);
    end
    tick();
    drain(20, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rw_drain: %0d entries left, required 0", sb.size()); end
    ovr_en = 1'b0;
  endtask

  task automatic test_redirect_req();
    bit ok;
    bit seen;
    reset_to(32'h40);
    @(negedge clk);
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h40) begin
      n_fail++;
      $display("FAIL rr_setup: valid=%b addr=%h required 1/00000040", imem_req_valid, imem_addr);
    end
    tick();
    imem_req_ready = 1'b1;
    redirect       = 1'b1;
    redirect_pc    = 32'h83;
    @(negedge clk);
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h40) begin
      n_fail++;
      $display("FAIL rr_old_issue: valid=%b addr=%h required 1/00000040", imem_req_valid, imem_addr);
    end
    tick();
    redirect = 1'b0;
    sb.push_back(mk(32'h80, word(32'h80)));
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (imem_req_valid) begin
        seen = 1'b1;
        break;
      end
      n_checks++;
      if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rr_dropped: inst_valid=%b inst=%h required 0", inst_valid, inst); end
    end
    n_checks++;
    if (!seen || imem_addr !== 32'h80) begin
      n_fail++;
      $display("FAIL rr_next_addr: addr=%h seen=%0b required 00000080", imem_addr, seen);
    end
    tick();
    drain(20, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rr_drain: %0d entries left, required 0", sb.size()); end
  endtask

  task automatic test_redirect_hold();
    bit ok;
    reset_to(32'h10);
    imem_req_ready = 1'b1;
    wait_iv(10, ok);
    n_checks++;
    if (!ok || inst_pc !== 32'h10) begin
      n_fail++;
      $display("FAIL rh_setup: inst_pc=%h valid_seen=%0b required 00000010", inst_pc, ok);
    end
    tick();
    inst_ready  = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h300;
    tick();
    inst_ready = 1'b0;
    redirect   = 1'b0;
    @(negedge clk);
    n_checks++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h300) begin
      n_fail++;
      $display("FAIL rh_next: iv=%b rv=%b addr=%h required 0/1/00000300", inst_valid, imem_req_valid, imem_addr);
    end
    sb.push_back(mk(32'h300, word(32'h300)));
    tick();
    drain(20, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rh_drain: %0d entries left, required 0", sb.size()); end
  endtask

  task automatic test_wrap();
    bit ok;
    reset_to(32'hFFFF_FFFC);
    imem_req_ready = 1'b1;
    sb.push_back(mk(32'hFFFF_FFFC, word(32'hFFFF_FFFC)));
    sb.push_back(mk(32'h0000_0000, word(32'h0000_0000)));
    drain(30, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL wrap_drain: %0d entries left, required 0", sb.size()); end
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    reset_to(32'h40);
    imem_req_ready = 1'b1;
    sb.push_back(mk(32'h40, word(32'h40)));
    drain(20, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rm_drain: %0d entries left, required 0", sb.size()); end
    wait_req(1'b1, 10, ok);
    n_checks++;
    if (!ok || imem_addr !== 32'h44 || inst_pc !== 32'h40 || inst !== word(32'h40)) begin
      n_fail++;
      $display("FAIL rm_setup: addr=%h inst_pc=%h inst=%h required 00000044/00000040/%h",
               imem_addr, inst_pc, inst, word(32'h40));
    end
    tick();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0 ||
        inst_pc !== 32'h0 || imem_addr !== RST_PC) begin
      n_fail++;
      $display("FAIL rm_async: rv=%b iv=%b inst=%h pc=%h addr=%h required 0/0/0/0/%h",
               imem_req_valid, inst_valid, inst, inst_pc, imem_addr, RST_PC);
    end
    imem_req_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    wait_req(1'b0, 5, ok);
    n_checks++;
    if (!ok || imem_addr !== RST_PC) begin
      n_fail++;
      $display("FAIL rm_restart: addr=%h seen=%0b required %h", imem_addr, ok, RST_PC);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect_wait();
    test_redirect_req();
    test_redirect_hold();
    test_wrap();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
